friscv_pmp_checker: RTL and testbench
=====================================

Name: friscv_pmp_checker

Overview:
Sequential PMP access checker. It accepts one physical-address access request at a time and walks the PMP regions serially, one region per cycle. It resolves the lowest-numbered matching region and returns an allow/fault verdict with a valid/ready handshake. It sits between the load/store and fetch units and the memory interface, and reads the pmpcfg/pmpaddr CSR values directly.

Parameters:
- XLEN, 32, CSR width (pmpaddr holds address bits [RLEN-1:2]).
- RLEN, 34, physical address width in bytes.
- NB_REGION, 16, number of implemented PMP regions (1..64).
- IDXW, $clog2(NB_REGION) (minimum 1), width of the region index.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- csr_pmpcfg  in  8*NB_REGION  pmpcfg bytes; region i is at [8*i+:8] (bit0 R, bit1 W, bit2 X, bits4:3 A, bit7 L).
- csr_pmpaddr  in  XLEN*NB_REGION  pmpaddr registers; region i is at [XLEN*i+:XLEN].
- req_valid  in  1  access request valid.
- req_ready  out  1  checker can accept a request.
- req_addr  in  RLEN  byte physical address.
- req_acc  in  3  access type, one-hot: bit0 read, bit1 write, bit2 execute.
- req_priv  in  2  privilege: 2'b11 = M; any other value = S/U.
- rsp_valid  out  1  verdict valid.
- rsp_ready  in  1  verdict consumed.
- rsp_allow  out  1  1 = access permitted.
- rsp_match  out  1  1 = some region matched.
- rsp_region  out  IDXW  index of the matching region (0 if none).

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_allow=0, rsp_match=0, rsp_region=0, FSM=IDLE, idx=0. req_ready rises in the first cycle after reset release.
- FSM states IDLE, SCAN, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, latch addr/acc/priv, clear the match flag, set idx=0, go to SCAN.
- SCAN:
  - req_ready=0.
  - Each cycle, evaluate region idx against the latched address using the live CSR values.
  - On the first match, record the region index and its cfg. Later matches are ignored: lowest index has priority.
  - When idx==NB_REGION-1, go to RESP. Otherwise idx++.
- RESP:
  - rsp_* outputs are registered and held stable while rsp_valid=1 && rsp_ready=0.
  - On rsp_ready, go to IDLE. The next request cannot be accepted in the same cycle.
- Latency: request accepted at cycle T; rsp_valid=1 at T+NB_REGION+1. Throughput is one request per NB_REGION+2 cycles minimum.
- Region decode, with top = pmpaddr[i]<<2 zero-extended to RLEN:
  - OFF: never matches.
  - TOR: matches when prev <= addr < top. prev = pmpaddr[i-1]<<2, or 0 for i=0. If prev >= top, no match.
  - NA4: matches when (addr & ~3) == (top & ~3).
  - NAPOT: t = number of trailing ones in pmpaddr; size = 2^(t+3); mask = ~0 << (t+3); matches when (addr & mask) == (top & mask). All-ones pmpaddr matches the whole space.
- Permission check on a match: perm = cfg[2:0] & req_acc.
  - M-mode with L=0: allow.
  - M-mode with L=1: allow only if perm != 0.
  - S/U: allow only if perm != 0.
- No match: allow if M-mode, deny otherwise.
- req_acc must be one-hot. A zero or multi-bit value yields rsp_allow=0 for any matched or S/U access.
- CSR values are sampled live during SCAN. Software must fence CSR writes before dependent accesses; no snapshot is taken.
- aresetn assertion mid-SCAN or mid-RESP returns to IDLE immediately and drops rsp_valid. The in-flight request is discarded.

Optional Feature:
- Macro: FRISCV_PMP_EARLY_EXIT_EN.
- Defined: SCAN exits to RESP in the cycle after the first match. A match at region k gives rsp_valid at T+k+2. With no match, latency is unchanged (T+NB_REGION+1).
- Undefined: fixed-latency full scan, as described above. This removes the timing side channel.

Test Plan:
- NB_REGION=4; all regions OFF; read at 0x1000 with priv=M, then priv=U -> allow=1, match=0; then allow=0, match=0; each rsp_valid at T+5.
- Region 1 TOR with pmpaddr0=0x400, pmpaddr1=0x800, cfg R; U read at 0x1FFC / 0x2000 / 0x0FFC -> allow=1 region=1 / match=0 deny / match=0 deny.
- Region 0 NAPOT pmpaddr=0x1FF (4 KB at 0x0), cfg RW; region 2 NA4 at 0x100 (pmpaddr=0x40), cfg X; U exec at 0x100 -> region=0, allow=0 (lowest index wins).
- M-mode write into a locked region with cfg R|L -> allow=0; same access with L=0 -> allow=1.
- Hold rsp_ready=0 for 3 cycles -> rsp_* stable and req_ready=0; pulse aresetn low during SCAN -> rsp_valid=0 and the next request proceeds normally.
- With FRISCV_PMP_EARLY_EXIT_EN, match at region 0 -> rsp_valid at T+2; with no match -> T+5.

Source files
------------

// File: rtl/friscv_pmp_checker.sv
// ============================================================================
// Module   : friscv_pmp_checker
// Brief    : Sequential PMP access checker walking one region per cycle and
//            returning the lowest-indexed match verdict over valid/ready.
//            Optional macro FRISCV_PMP_EARLY_EXIT_EN ends the scan at the
//            first match instead of always walking every region.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module friscv_pmp_checker #(
    parameter int XLEN      = 32,
    parameter int RLEN      = 34,
    parameter int NB_REGION = 16,
    parameter int IDXW      = (NB_REGION > 1) ? $clog2(NB_REGION) : 1
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [8*NB_REGION-1:0]    csr_pmpcfg,
    input  logic [XLEN*NB_REGION-1:0] csr_pmpaddr,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [RLEN-1:0]           req_addr,
    input  logic [2:0]                req_acc,
    input  logic [1:0]                req_priv,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      rsp_allow,
    output logic                      rsp_match,
    output logic [IDXW-1:0]           rsp_region
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_req_ready;
    logic [IDXW-1:0]   r_idx;
    logic [RLEN-1:0]   r_addr;
    logic [2:0]        r_acc;
    logic [1:0]        r_priv;
    logic              r_match;
    logic [IDXW-1:0]   r_region;
    logic [2:0]        r_perm;
    logic              r_lock;
    logic              r_rsp_valid;
    logic              r_rsp_allow;
    logic              r_rsp_match;
    logic [IDXW-1:0]   r_rsp_region;

    logic              w_accept;
    logic              w_scan_done;
    logic              w_last;

    logic [XLEN-1:0]   w_pmpaddr [NB_REGION];
    logic [XLEN-1:0]   w_pmpprev [NB_REGION];
    logic [7:0]        w_pmpcfg  [NB_REGION];

    logic [XLEN-1:0]   w_cur_addr;
    logic [XLEN-1:0]   w_cur_prev;
    logic [7:0]        w_cur_cfg;
    logic [RLEN-1:0]   w_top;
    logic [RLEN-1:0]   w_prev;
    logic [XLEN-1:0]   w_tm;
    logic [RLEN-1:0]   w_napot_mask;
    logic              w_cur_match;
    logic [1:0]        w_unused_cfg;

    logic              w_fin_match;
    logic [2:0]        w_fin_perm;
    logic              w_fin_lock;
    logic [IDXW-1:0]   w_fin_region;
    logic              w_is_m;
    logic              w_allow;

    generate
        for (genvar i = 0; i < NB_REGION; i++) begin : g_unpack
            assign w_pmpaddr[i] = csr_pmpaddr[XLEN*i +: XLEN];
            assign w_pmpcfg[i]  = csr_pmpcfg[8*i +: 8];
            if (i == 0) begin : g_first
                assign w_pmpprev[i] = '0;
            end else begin : g_rest
                assign w_pmpprev[i] = csr_pmpaddr[XLEN*(i-1) +: XLEN];
            end
        end
    endgenerate

    // CSRs are read live; no snapshot is taken at request acceptance
    assign w_cur_addr   = w_pmpaddr[r_idx];
    assign w_cur_prev   = w_pmpprev[r_idx];
    assign w_cur_cfg    = w_pmpcfg[r_idx];
    assign w_unused_cfg = w_cur_cfg[6:5];

    assign w_top  = RLEN'({w_cur_addr, 2'b00});
    assign w_prev = RLEN'({w_cur_prev, 2'b00});

    // w_tm[i] is set while pmpaddr[i:0] is all ones (NAPOT size encoding)
    generate
        for (genvar i = 0; i < XLEN; i++) begin : g_tm
            assign w_tm[i] = &w_cur_addr[i:0];
        end
    endgenerate

    assign w_napot_mask = ~RLEN'({w_tm, 3'b111});

    always_comb begin
        w_cur_match = 1'b0;
        case (w_cur_cfg[4:3])
            2'b01:   w_cur_match = (w_prev < w_top) && (r_addr >= w_prev) && (r_addr < w_top);
            2'b10:   w_cur_match = (r_addr[RLEN-1:2] == w_top[RLEN-1:2]);
            2'b11:   w_cur_match = ((r_addr & w_napot_mask) == (w_top & w_napot_mask));
            default: w_cur_match = 1'b0;
        endcase
    end

    assign w_last = (r_idx == IDXW'(NB_REGION - 1));

    // Final verdict folds the region under evaluation this cycle
    assign w_fin_match  = r_match | w_cur_match;
    assign w_fin_perm   = r_match ? r_perm   : w_cur_cfg[2:0];
    assign w_fin_lock   = r_match ? r_lock   : w_cur_cfg[7];
    assign w_fin_region = r_match ? r_region : r_idx;
    assign w_is_m       = (r_priv == 2'b11);

    always_comb begin
        w_allow = 1'b0;
        if (w_fin_match) begin
            w_allow = $onehot(r_acc) && ((w_is_m && !w_fin_lock) || (|(w_fin_perm & r_acc)));
        end else begin
            w_allow = w_is_m;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_scan_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid && r_req_ready) begin
                    w_state_nxt = S_SCAN;
                    w_accept    = 1'b1;
                end
            end
            S_SCAN: begin
`ifdef FRISCV_PMP_EARLY_EXIT_EN
                if (w_cur_match || w_last) begin
`else
                if (w_last) begin
`endif
                    w_state_nxt = S_RESP;
                    w_scan_done = 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_req_ready  <= 1'b0;
            r_idx        <= '0;
            r_addr       <= '0;
            r_acc        <= '0;
            r_priv       <= '0;
            r_match      <= 1'b0;
            r_region     <= '0;
            r_perm       <= '0;
            r_lock       <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_allow  <= 1'b0;
            r_rsp_match  <= 1'b0;
            r_rsp_region <= '0;
        end else begin
            r_req_ready <= (w_state_nxt == S_IDLE);
            if (w_accept) begin
                r_addr  <= req_addr;
                r_acc   <= req_acc;
                r_priv  <= req_priv;
                r_match <= 1'b0;
                r_idx   <= '0;
            end
            if (r_state == S_SCAN) begin
                if (w_cur_match && !r_match) begin
                    r_match  <= 1'b1;
                    r_region <= r_idx;
                    r_perm   <= w_cur_cfg[2:0];
                    r_lock   <= w_cur_cfg[7];
                end
                if (!w_last) begin
                    r_idx <= r_idx + IDXW'(1);
                end
            end
            if (w_scan_done) begin
                r_rsp_valid  <= 1'b1;
                r_rsp_allow  <= w_allow;
                r_rsp_match  <= w_fin_match;
                r_rsp_region <= w_fin_match ? w_fin_region : '0;
            end else if ((r_state == S_RESP) && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign req_ready  = r_req_ready;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_allow  = r_rsp_allow;
    assign rsp_match  = r_rsp_match;
    assign rsp_region = r_rsp_region;

endmodule

`default_nettype wire

// File: tb/tb_friscv_pmp_checker.sv
// ============================================================================
// Module   : tb_friscv_pmp_checker
// Brief    : Directed self-checking bench for friscv_pmp_checker (4 regions).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_friscv_pmp_checker;

    localparam int XLEN      = 32;
    localparam int RLEN      = 34;
    localparam int NB_REGION = 4;
    localparam int IDXW      = 2;

    localparam logic [2:0] ACC_R = 3'b001;
    localparam logic [2:0] ACC_W = 3'b010;
    localparam logic [2:0] ACC_X = 3'b100;
    localparam logic [1:0] PRV_M = 2'b11;
    localparam logic [1:0] PRV_U = 2'b00;

    logic                      aclk;
    logic                      aresetn;
    logic [8*NB_REGION-1:0]    csr_pmpcfg;
    logic [XLEN*NB_REGION-1:0] csr_pmpaddr;
    logic                      req_valid;
    logic                      req_ready;
    logic [RLEN-1:0]           req_addr;
    logic [2:0]                req_acc;
    logic [1:0]                req_priv;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic                      rsp_allow;
    logic                      rsp_match;
    logic [IDXW-1:0]           rsp_region;

    int checks;
    int failures;

    friscv_pmp_checker #(
        .XLEN      (XLEN),
        .RLEN      (RLEN),
        .NB_REGION (NB_REGION),
        .IDXW      (IDXW)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .csr_pmpcfg  (csr_pmpcfg),
        .csr_pmpaddr (csr_pmpaddr),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_acc     (req_acc),
        .req_priv    (req_priv),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_allow   (rsp_allow),
        .rsp_match   (rsp_match),
        .rsp_region  (rsp_region)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_region(input int i, input logic [7:0] cfg, input logic [XLEN-1:0] addr);
        csr_pmpcfg[8*i +: 8]        = cfg;
        csr_pmpaddr[XLEN*i +: XLEN] = addr;
    endtask

    task automatic clear_regions();
        csr_pmpcfg  = '0;
        csr_pmpaddr = '0;
    endtask

    task automatic wait_ready(input string tag);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge aclk);
            #1;
        end
        if (!ok) chk({tag, "_ready_timeout"}, 64'(req_ready), 64'd1);
    endtask

    // Accept a request, wait for the verdict and check it, then consume it
    task automatic run(input string tag, input logic [RLEN-1:0] a, input logic [2:0] acc,
                       input logic [1:0] priv, input logic ea, input logic em,
                       input logic [IDXW-1:0] er);
        int lat;
        int exp_lat;
        bit got;
`ifdef FRISCV_PMP_EARLY_EXIT_EN
        exp_lat = em ? int'(er) + 2 : NB_REGION + 1;
`else
        exp_lat = NB_REGION + 1;
`endif
        wait_ready(tag);
        req_addr  = a;
        req_acc   = acc;
        req_priv  = priv;
        req_valid = 1'b1;
        @(posedge aclk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        got = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
            @(posedge aclk);
            #1;
            lat++;
        end
        chk({tag, "_rsp_seen"}, 64'(got), 64'd1);
        if (got) begin
            chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
            chk({tag, "_allow"}, 64'(rsp_allow), 64'(ea));
            chk({tag, "_match"}, 64'(rsp_match), 64'(em));
            chk({tag, "_region"}, 64'(rsp_region), 64'(er));
            chk({tag, "_busy"}, 64'(req_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        @(posedge aclk);
        #1;
        rsp_ready = 1'b0;
        chk({tag, "_drop"}, 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        int  hold_ok;
        bit  got;
        checks      = 0;
        failures    = 0;
        aresetn     = 1'b0;
        req_valid   = 1'b0;
        req_addr    = '0;
        req_acc     = '0;
        req_priv    = '0;
        rsp_ready   = 1'b0;
        clear_regions();

        repeat (3) @(posedge aclk);
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_allow", 64'(rsp_allow), 64'd0);
        chk("rst_rsp_match", 64'(rsp_match), 64'd0);
        chk("rst_rsp_region", 64'(rsp_region), 64'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        chk("rel_req_ready", 64'(req_ready), 64'd1);

        // All regions OFF
        run("off_m", 34'h1000, ACC_R, PRV_M, 1'b1, 1'b0, 2'd0);
        run("off_u", 34'h1000, ACC_R, PRV_U, 1'b0, 1'b0, 2'd0);

        // Region 1 TOR [0x1000, 0x2000) read-only
        clear_regions();
        set_region(0, 8'h00, 32'h400);
        set_region(1, 8'h09, 32'h800);
        run("tor_in",   34'h1FFC, ACC_R, PRV_U, 1'b1, 1'b0 | 1'b1, 2'd1);
        run("tor_top",  34'h2000, ACC_R, PRV_U, 1'b0, 1'b0, 2'd0);
        run("tor_low",  34'h0FFC, ACC_R, PRV_U, 1'b0, 1'b0, 2'd0);
        run("tor_base", 34'h1000, ACC_R, PRV_U, 1'b1, 1'b1, 2'd1);
        run("tor_wr",   34'h1000, ACC_W, PRV_U, 1'b0, 1'b1, 2'd1);
        // prev >= top never matches
        set_region(0, 8'h00, 32'h800);
        set_region(1, 8'h09, 32'h400);
        run("tor_inv",  34'h1800, ACC_R, PRV_U, 1'b0, 1'b0, 2'd0);

        // NAPOT 4 KB at 0 (RW) overlaps NA4 at 0x100 (X): region 0 wins
        clear_regions();
        set_region(0, 8'h1B, 32'h1FF);
        set_region(2, 8'h14, 32'h40);
        run("prio_x",   34'h100,  ACC_X, PRV_U, 1'b0, 1'b1, 2'd0);
        run("napot_rw", 34'hFFC,  ACC_W, PRV_U, 1'b1, 1'b1, 2'd0);
        run("napot_out",34'h1000, ACC_R, PRV_U, 1'b0, 1'b0, 2'd0);
        set_region(0, 8'h00, 32'h1FF);
        run("na4_in",   34'h103,  ACC_X, PRV_U, 1'b1, 1'b1, 2'd2);
        run("na4_out",  34'h104,  ACC_X, PRV_U, 1'b0, 1'b0, 2'd0);

        // All-ones NAPOT covers the whole physical space
        clear_regions();
        set_region(3, 8'h19, 32'hFFFF_FFFF);
        run("napot_all", 34'h3_0000_0000, ACC_R, PRV_U, 1'b1, 1'b1, 2'd3);

        // Locked region enforces permissions on M-mode
        clear_regions();
        set_region(0, 8'h99, 32'h1FF);
        run("lock_wr", 34'h10, ACC_W, PRV_M, 1'b0, 1'b1, 2'd0);
        run("lock_rd", 34'h10, ACC_R, PRV_M, 1'b1, 1'b1, 2'd0);
        set_region(0, 8'h19, 32'h1FF);
        run("unlock_wr", 34'h10, ACC_W, PRV_M, 1'b1, 1'b1, 2'd0);
        run("multi_acc", 34'h10, 3'b011, PRV_M, 1'b0, 1'b1, 2'd0);
        run("nomatch_m0", 34'h5000, 3'b000, PRV_M, 1'b1, 1'b0, 2'd0);

        // Back-pressure: verdict must hold while rsp_ready stays low
        wait_ready("hold");
        req_addr  = 34'h20;
        req_acc   = ACC_R;
        req_priv  = PRV_U;
        req_valid = 1'b1;
        @(posedge aclk);
        #1;
        req_valid = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
            @(posedge aclk);
            #1;
        end
        chk("hold_rsp_seen", 64'(got), 64'd1);
        hold_ok = 0;
        for (int n = 0; n < 3; n++) begin
            @(posedge aclk);
            #1;
            if (rsp_valid && rsp_allow && rsp_match && (rsp_region == 2'd0) && !req_ready)
                hold_ok++;
        end
        chk("hold_stable", 64'(hold_ok), 64'd3);
        rsp_ready = 1'b1;
        @(posedge aclk);
        #1;
        rsp_ready = 1'b0;
        chk("hold_drop", 64'(rsp_valid), 64'd0);

        // Reset asserted mid-scan discards the request
        wait_ready("midrst");
        req_addr  = 34'h20;
        req_acc   = ACC_R;
        req_priv  = PRV_U;
        req_valid = 1'b1;
        @(posedge aclk);
        #1;
        req_valid = 1'b0;
        @(posedge aclk);
        #1;
        aresetn = 1'b0;
        #1;
        chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("midrst_req_ready", 64'(req_ready), 64'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        chk("midrst_no_rsp", 64'(rsp_valid), 64'd0);
        run("after_rst", 34'h20, ACC_R, PRV_U, 1'b1, 1'b1, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
